// File: rtl/itrace_dct_packer.sv
// itrace_dct_packer
//   Direct-compressed-trace packer for the OCI instruction-trace path.
//   Packs retired conditional-branch outcomes as 2-bit codes into a
//   30-bit (15-slot) buffer. Full or flushed buffers are handed to the
//   trace FIFO through a single-entry valid/ready frame slot.
//   Code map: 2'b10 = taken, 2'b01 = not taken, 2'b00 = empty slot.
//   Optional build macro ITRACE_DROP_COUNTER_EN adds a saturating
//   16-bit drop_count output next to the sticky overflow flag.
module itrace_dct_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        trace_en,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic        flush_req,
    input  logic        test_end_req,
    input  logic        frame_ready,
    output logic        frame_valid,
    output logic [29:0] frame_data,
    output logic [3:0]  frame_cnt,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        test_ending,
    output logic        test_has_ended,
    output logic        overflow
`ifdef ITRACE_DROP_COUNTER_EN
    ,
    output logic [15:0] drop_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } te_state_t;

    te_state_t   state;
    te_state_t   state_nxt;

    logic        flush_pend;
    logic        ev;
    logic        append;
    logic        drop;
    logic        close;
    logic        slot_free;
    logic        load;
    logic        accept;
    logic [29:0] dct_buffer_nxt;
    logic [3:0]  dct_count_nxt;

    // Append/drop decision and frame close condition for this cycle
    always_comb begin
        ev             = br_valid & trace_en & (state == ST_IDLE);
        append         = ev & (dct_count != 4'd15);
        drop           = ev & (dct_count == 4'd15);
        dct_buffer_nxt = dct_buffer;
        dct_count_nxt  = dct_count;
        if (append) begin
            dct_buffer_nxt = {dct_buffer[27:0], (br_taken ? 2'b10 : 2'b01)};
            dct_count_nxt  = dct_count + 4'd1;
        end
        slot_free = ~frame_valid | frame_ready;
        accept    = frame_valid & frame_ready;
        close     = (dct_count_nxt == 4'd15) |
                    ((flush_req | flush_pend | test_ending) & (dct_count_nxt != 4'd0));
        load      = close & slot_free;
    end

    // Test-end sequencing: drain the buffer and frame slot, then stay done
    always_comb begin
        state_nxt      = state;
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        case (state)
            ST_IDLE: begin
                if (test_end_req) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                test_ending = 1'b1;
                // Done once nothing is buffered, loading, or left unaccepted in the slot
                if ((dct_count == 4'd0) && !load && (!frame_valid || frame_ready)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                test_has_ended = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Test-end state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Packing buffer, frame slot and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            dct_buffer  <= '0;
            dct_count   <= '0;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            frame_cnt   <= '0;
            flush_pend  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (load) begin
                frame_data  <= dct_buffer_nxt;
                frame_cnt   <= dct_count_nxt;
                frame_valid <= 1'b1;
                dct_buffer  <= '0;
                dct_count   <= '0;
                flush_pend  <= 1'b0;
            end else begin
                dct_buffer <= dct_buffer_nxt;
                dct_count  <= dct_count_nxt;
                // Remember a flush that could not close because the slot was busy
                if (flush_req && (dct_count_nxt != 4'd0)) begin
                    flush_pend <= 1'b1;
                end
                if (accept) begin
                    frame_valid <= 1'b0;
                end
            end
        end
    end

`ifdef ITRACE_DROP_COUNTER_EN
    // Saturating count of dropped branch events
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_itrace_dct_packer.sv
// tb_itrace_dct_packer
//   Directed bench for itrace_dct_packer; expected values are hand-computed.
//   Builds with or without ITRACE_DROP_COUNTER_EN.
module tb_itrace_dct_packer;

    logic        clk;
    logic        reset;
    logic        trace_en;
    logic        br_valid;
    logic        br_taken;
    logic        flush_req;
    logic        test_end_req;
    logic        frame_ready;
    logic        frame_valid;
    logic [29:0] frame_data;
    logic [3:0]  frame_cnt;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;
    logic        overflow;
`ifdef ITRACE_DROP_COUNTER_EN
    logic [15:0] drop_count;
`endif

    int unsigned checks;
    int unsigned errors;

    itrace_dct_packer dut (
        .clk            (clk),
        .reset          (reset),
        .trace_en       (trace_en),
        .br_valid       (br_valid),
        .br_taken       (br_taken),
        .flush_req      (flush_req),
        .test_end_req   (test_end_req),
        .frame_ready    (frame_ready),
        .frame_valid    (frame_valid),
        .frame_data     (frame_data),
        .frame_cnt      (frame_cnt),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .overflow       (overflow)
`ifdef ITRACE_DROP_COUNTER_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        br_valid     = 1'b0;
        flush_req    = 1'b0;
        test_end_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic events(input int unsigned n, input logic taken);
        for (int unsigned i = 0; i < n; i++) begin
            br_valid = 1'b1;
            br_taken = taken;
            tick();
        end
        br_valid = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        trace_en     = 1'b1;
        br_taken     = 1'b0;
        frame_ready  = 1'b1;
        do_reset();

        // Reset state
        check("rst_valid",   {31'd0, frame_valid}, 32'd0);
        check("rst_data",    {2'd0, frame_data}, 32'd0);
        check("rst_count",   {28'd0, dct_count}, 32'd0);
        check("rst_buffer",  {2'd0, dct_buffer}, 32'd0);
        check("rst_flags",   {28'd0, test_ending, test_has_ended, overflow, frame_cnt != 4'd0}, 32'd0);

        // trace_en low ignores branches
        trace_en = 1'b0;
        events(3, 1'b1);
        check("te0_count", {28'd0, dct_count}, 32'd0);
        trace_en = 1'b1;

        // 15 taken branches close a full frame
        events(15, 1'b1);
        check("full_valid", {31'd0, frame_valid}, 32'd1);
        check("full_data",  {2'd0, frame_data}, 32'h2AAAAAAA);
        check("full_cnt",   {28'd0, frame_cnt}, 32'd15);
        check("full_count", {28'd0, dct_count}, 32'd0);
        tick();
        check("full_acc",   {31'd0, frame_valid}, 32'd0);

        // T, NT, T then flush
        events(1, 1'b1);
        events(1, 1'b0);
        events(1, 1'b1);
        check("fl_buf", {2'd0, dct_buffer}, 32'h26);
        flush_req = 1'b1;
        tick();
        check("fl_valid", {31'd0, frame_valid}, 32'd1);
        check("fl_data",  {2'd0, frame_data}, 32'h26);
        check("fl_cnt",   {28'd0, frame_cnt}, 32'd3);
        tick();   // second flush with an empty buffer
        flush_req = 1'b0;
        check("fl_empty", {31'd0, frame_valid}, 32'd0);
        tick();
        check("fl_empty2", {31'd0, frame_valid}, 32'd0);

        // Backpressure: frame A held, buffer fills, 16th event drops
        frame_ready = 1'b0;
        events(15, 1'b1);
        check("bp_validA", {31'd0, frame_valid}, 32'd1);
        check("bp_ovf0",   {31'd0, overflow}, 32'd0);
        events(16, 1'b0);
        check("bp_count",  {28'd0, dct_count}, 32'd15);
        check("bp_buffer", {2'd0, dct_buffer}, 32'h15555555);
        check("bp_ovf",    {31'd0, overflow}, 32'd1);
        check("bp_dataA",  {2'd0, frame_data}, 32'h2AAAAAAA);
`ifdef ITRACE_DROP_COUNTER_EN
        check("bp_drops",  {16'd0, drop_count}, 32'd1);
`endif
        frame_ready = 1'b1;
        tick();
        check("bp_validB", {31'd0, frame_valid}, 32'd1);
        check("bp_dataB",  {2'd0, frame_data}, 32'h15555555);
        check("bp_cntB",   {28'd0, frame_cnt}, 32'd15);
        check("bp_count0", {28'd0, dct_count}, 32'd0);
        tick();
        check("bp_accB",   {31'd0, frame_valid}, 32'd0);
        check("bp_ovf_sticky", {31'd0, overflow}, 32'd1);

        // Event and flush together at count 2
        do_reset();
        check("ovf_cleared", {31'd0, overflow}, 32'd0);
        events(2, 1'b1);
        br_valid  = 1'b1;
        br_taken  = 1'b0;
        flush_req = 1'b1;
        tick();
        br_valid  = 1'b0;
        flush_req = 1'b0;
        check("ef_cnt",  {28'd0, frame_cnt}, 32'd3);
        check("ef_data", {2'd0, frame_data}, 32'h29);
        check("ef_count", {28'd0, dct_count}, 32'd0);
        tick();

        // End-of-test drain
        do_reset();
        events(5, 1'b1);
        test_end_req = 1'b1;
        tick();
        test_end_req = 1'b0;
        check("te_ending", {31'd0, test_ending}, 32'd1);
        check("te_nofr",   {31'd0, frame_valid}, 32'd0);
        tick();
        check("te_valid",  {31'd0, frame_valid}, 32'd1);
        check("te_cnt",    {28'd0, frame_cnt}, 32'd5);
        check("te_data",   {2'd0, frame_data}, 32'h2AA);
        check("te_ended0", {31'd0, test_has_ended}, 32'd0);
        tick();
        check("te_ended",  {31'd0, test_has_ended}, 32'd1);
        check("te_end_lo", {31'd0, test_ending}, 32'd0);
        events(3, 1'b1);
        check("te_ignore", {28'd0, dct_count}, 32'd0);
        check("te_sticky", {31'd0, test_has_ended}, 32'd1);

        // Reset mid-frame
        do_reset();
        frame_ready = 1'b0;
        events(15, 1'b1);
        events(7, 1'b0);
        check("rm_pre_v", {31'd0, frame_valid}, 32'd1);
        check("rm_pre_c", {28'd0, dct_count}, 32'd7);
        reset       = 1'b1;
        frame_ready = 1'b1;
        tick();
        reset = 1'b0;
        check("rm_valid", {31'd0, frame_valid}, 32'd0);
        check("rm_count", {28'd0, dct_count}, 32'd0);
        check("rm_data",  {2'd0, frame_data}, 32'd0);
        check("rm_buf",   {2'd0, dct_buffer}, 32'd0);
        tick();
        check("rm_valid2", {31'd0, frame_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
